// File: rtl/bus_req_arbiter_pkg.sv
// Shared types and constants for the two-CPU snooping-bus request arbiter.
package bus_req_arbiter_pkg;

   typedef enum logic [1:0] {
      OP_READ_MISS  = 2'b00,
      OP_WRITE_MISS = 2'b01,
      OP_INVALIDATE = 2'b10,
      OP_NONE       = 2'b11
   } bus_req_op_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_BUSY = 2'b01,
      ARB_DONE = 2'b10
   } arb_state_t;

   localparam logic SRC_CPU0 = 1'b0;
   localparam logic SRC_CPU1 = 1'b1;

endpackage

// File: rtl/bus_req_arbiter_if.sv
// Request/grant/bus bundle between the two CPUs, the bus and the arbiter.
interface bus_req_arbiter_if #(
   parameter int unsigned ADDR_W = 11
);
   import bus_req_arbiter_pkg::*;

   logic              req_0;
   bus_req_op_t       op_0;
   logic [ADDR_W-1:0] addr_0;
   logic              req_1;
   bus_req_op_t       op_1;
   logic [ADDR_W-1:0] addr_1;
   logic              bus_done;

   logic              bus_valid;
   bus_req_op_t       bus_op;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_src;
   logic              grant_0;
   logic              grant_1;
   logic              ack_0;
   logic              ack_1;
   logic              timeout_err;

   // Requesters and bus side.
   modport master (
      output req_0, op_0, addr_0, req_1, op_1, addr_1, bus_done,
      input  bus_valid, bus_op, bus_addr, bus_src,
      input  grant_0, grant_1, ack_0, ack_1, timeout_err
   );

   // Arbiter side.
   modport slave (
      input  req_0, op_0, addr_0, req_1, op_1, addr_1, bus_done,
      output bus_valid, bus_op, bus_addr, bus_src,
      output grant_0, grant_1, ack_0, ack_1, timeout_err
   );

endinterface

// File: rtl/bus_req_arbiter_watchdog.sv
// Transaction watchdog: counts BUSY cycles and flags the final allowed cycle.
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] count_q;

   // Saturating cycle counter, cleared at the start of each transaction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   // Decoded from the counter flops so the arbiter can act on it this cycle.
   assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_req_arbiter.sv
// Round-robin front-end scheduler for the two-CPU snooping bus.
module bus_req_arbiter
   import bus_req_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W         = 11,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic         clk,
   input logic         rst_n,
   bus_req_arbiter_if.slave bus
);

   arb_state_t        state_q, state_d;
   bus_req_op_t       op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              src_q, src_d;
   logic              err_q, err_d;
   logic              last_q, last_d;

   logic              valid_0, valid_1, pick;
   logic              expired;
   logic              wd_clr, wd_en;

   logic              bus_valid_d, bus_src_d;
   bus_req_op_t       bus_op_d;
   logic [ADDR_W-1:0] bus_addr_d;
   logic              grant_0_d, grant_1_d, ack_0_d, ack_1_d, timeout_err_d;

   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (expired)
   );

   // State, latched transaction and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ARB_IDLE;
         op_q            <= OP_NONE;
         addr_q          <= '0;
         src_q           <= SRC_CPU0;
         err_q           <= 1'b0;
         last_q          <= SRC_CPU1;
         bus.bus_valid   <= 1'b0;
         bus.bus_op      <= OP_NONE;
         bus.bus_addr    <= '0;
         bus.bus_src     <= 1'b0;
         bus.grant_0     <= 1'b0;
         bus.grant_1     <= 1'b0;
         bus.ack_0       <= 1'b0;
         bus.ack_1       <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         addr_q          <= addr_d;
         src_q           <= src_d;
         err_q           <= err_d;
         last_q          <= last_d;
         bus.bus_valid   <= bus_valid_d;
         bus.bus_op      <= bus_op_d;
         bus.bus_addr    <= bus_addr_d;
         bus.bus_src     <= bus_src_d;
         bus.grant_0     <= grant_0_d;
         bus.grant_1     <= grant_1_d;
         bus.ack_0       <= ack_0_d;
         bus.ack_1       <= ack_1_d;
         bus.timeout_err <= timeout_err_d;
      end
   end

   // Next-state, latch capture and next output values.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      src_d   = src_q;
      err_d   = err_q;
      last_d  = last_q;
      pick    = SRC_CPU0;

      valid_0 = bus.req_0 && (bus.op_0 != OP_NONE);
      valid_1 = bus.req_1 && (bus.op_1 != OP_NONE);

      case (state_q)
         ARB_IDLE: begin
            if (valid_0 || valid_1) begin
               // On a tie, serve whoever was not served most recently.
               if (valid_0 && valid_1) pick = ~last_q;
               else                    pick = valid_1 ? SRC_CPU1 : SRC_CPU0;
               src_d   = pick;
               op_d    = pick ? bus.op_1   : bus.op_0;
               addr_d  = pick ? bus.addr_1 : bus.addr_0;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (bus.bus_done) begin
               err_d   = 1'b0;
               state_d = ARB_DONE;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ARB_DONE;
            end
         end
         ARB_DONE: begin
            last_d  = src_q;
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      wd_clr = (state_q == ARB_IDLE) && (state_d == ARB_BUSY);
      wd_en  = (state_q == ARB_BUSY);

      bus_valid_d   = (state_d == ARB_BUSY);
      bus_op_d      = bus_valid_d ? op_d   : OP_NONE;
      bus_addr_d    = bus_valid_d ? addr_d : '0;
      bus_src_d     = bus_valid_d ? src_d  : 1'b0;
      grant_0_d     = (state_d != ARB_IDLE) && (src_d == SRC_CPU0);
      grant_1_d     = (state_d != ARB_IDLE) && (src_d == SRC_CPU1);
      ack_0_d       = (state_d == ARB_DONE) && (src_d == SRC_CPU0);
      ack_1_d       = (state_d == ARB_DONE) && (src_d == SRC_CPU1);
      timeout_err_d = (state_d == ARB_DONE) && err_d;
   end

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Scoreboard bench for bus_req_arbiter: directed requests push expectations,
// a negedge monitor checks every ack against them.
module tb_bus_req_arbiter;
   import bus_req_arbiter_pkg::*;

   typedef struct {
      logic        src;
      bus_req_op_t op;
      logic [10:0] addr;
      logic        err;
      int          busy;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   exp_t exp_q[$];

   bus_req_arbiter_if #(.ADDR_W(11)) ifc ();

   bus_req_arbiter #(
      .ADDR_W         (11),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "bench hung");
   end

   // Monitor: per-cycle invariants, busy-cycle tally and ack scoreboard.
   initial begin
      int          busy_cnt;
      bus_req_op_t seen_op;
      logic [10:0] seen_addr;
      logic        seen_src;
      exp_t        e;
      busy_cnt  = 0;
      seen_op   = OP_NONE;
      seen_addr = '0;
      seen_src  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt = 0;
         end else begin
            n_tests++;
            if (ifc.grant_0 && ifc.grant_1) begin
               n_fail++;
               $display("FAIL grant_overlap: grant_0=%b grant_1=%b, required not both", ifc.grant_0, ifc.grant_1);
            end
            if ((ifc.ack_0 && !ifc.grant_0) || (ifc.ack_1 && !ifc.grant_1) || (ifc.ack_0 && ifc.ack_1)) begin
               n_fail++;
               $display("FAIL ack_grant: ack=%b%b grant=%b%b", ifc.ack_1, ifc.ack_0, ifc.grant_1, ifc.grant_0);
            end
            if (ifc.timeout_err && !(ifc.ack_0 || ifc.ack_1)) begin
               n_fail++;
               $display("FAIL err_without_ack: timeout_err=1 with no ack");
            end
            if (ifc.bus_valid) begin
               busy_cnt++;
               seen_op   = ifc.bus_op;
               seen_addr = ifc.bus_addr;
               seen_src  = ifc.bus_src;
            end
            if (ifc.ack_0 || ifc.ack_1) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_ack: ack=%b%b with empty scoreboard", ifc.ack_1, ifc.ack_0);
               end else begin
                  e = exp_q.pop_front();
                  if (ifc.ack_1 != e.src || seen_src != e.src || seen_op != e.op ||
                      seen_addr != e.addr || ifc.timeout_err != e.err || busy_cnt != e.busy) begin
                     n_fail++;
                     $display("FAIL ack_check: got src=%b bus_src=%b op=%0d addr=%h err=%b busy=%0d, required src=%b op=%0d addr=%h err=%b busy=%0d",
                              ifc.ack_1, seen_src, seen_op, seen_addr, ifc.timeout_err, busy_cnt,
                              e.src, e.op, e.addr, e.err, e.busy);
                  end
               end
               busy_cnt = 0;
            end
         end
      end
   end

   task automatic push_exp(input logic src, input bus_req_op_t op, input logic [10:0] addr,
                           input logic err, input int busy);
      exp_t e;
      e.src = src; e.op = op; e.addr = addr; e.err = err; e.busy = busy;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input logic src, input bus_req_op_t op, input logic [10:0] addr);
      if (src) begin ifc.req_1 = 1'b1; ifc.op_1 = op; ifc.addr_1 = addr; end
      else     begin ifc.req_0 = 1'b1; ifc.op_0 = op; ifc.addr_0 = addr; end
   endtask

   // Wait for grant_src, pulse bus_done on BUSY cycle done_k (0 = never), drop req on ack.
   task automatic serve(input logic src, input int done_k, input bit scramble, output int wait_cyc);
      bit got;
      wait_cyc = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         wait_cyc++;
         if (src ? ifc.grant_1 : ifc.grant_0) got = 1'b1;
      end
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL grant_wait: no grant for src %b within 20 cycles", src);
         if (src) ifc.req_1 = 1'b0; else ifc.req_0 = 1'b0;
         return;
      end
      got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         if (scramble && k == 1) begin
            if (src) begin ifc.addr_1 = 11'h7FF; ifc.op_1 = OP_INVALIDATE; end
            else     begin ifc.addr_0 = 11'h7FF; ifc.op_0 = OP_INVALIDATE; end
         end
         ifc.bus_done = (k == done_k);
         @(posedge clk); #1;
         ifc.bus_done = 1'b0;
         if (src ? ifc.ack_1 : ifc.ack_0) begin
            got = 1'b1;
            if (src) ifc.req_1 = 1'b0; else ifc.req_0 = 1'b0;
         end
      end
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL ack_wait: no ack for src %b within 40 cycles", src);
         if (src) ifc.req_1 = 1'b0; else ifc.req_0 = 1'b0;
      end
   endtask

   task automatic check_idle_outputs(input string name);
      logic [18:0] act, req;
      act = {ifc.bus_valid, ifc.bus_op, ifc.bus_addr, ifc.bus_src, ifc.grant_0, ifc.grant_1,
             ifc.ack_0, ifc.ack_1, ifc.timeout_err};
      req = {1'b0, 2'b11, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: outputs=%h, required %h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int w;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      ifc.req_0 = 1'b0; ifc.op_0 = OP_NONE; ifc.addr_0 = '0;
      ifc.req_1 = 1'b0; ifc.op_1 = OP_NONE; ifc.addr_1 = '0;
      ifc.bus_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_idle_outputs("reset_state");

      // Single cpu0 read miss, bus_done on 2nd BUSY cycle; grant one cycle after req.
      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_READ_MISS, 11'h123);
      push_exp(SRC_CPU0, OP_READ_MISS, 11'h123, 1'b0, 2);
      serve(SRC_CPU0, 2, 1'b0, w);
      n_tests++;
      if (w != 1) begin
         n_fail++;
         $display("FAIL req_to_valid_latency: %0d cycles, required 1", w);
      end

      // Simultaneous requests from reset: cpu0, cpu1, then cpu0 re-requests and loses to cpu1.
      do_reset();
      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_WRITE_MISS, 11'h010);
      set_req(SRC_CPU1, OP_READ_MISS,  11'h020);
      push_exp(SRC_CPU0, OP_WRITE_MISS, 11'h010, 1'b0, 1);
      push_exp(SRC_CPU1, OP_READ_MISS,  11'h020, 1'b0, 3);
      serve(SRC_CPU0, 1, 1'b0, w);
      serve(SRC_CPU1, 3, 1'b0, w);

      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_READ_MISS,  11'h031);
      set_req(SRC_CPU1, OP_WRITE_MISS, 11'h032);
      push_exp(SRC_CPU0, OP_READ_MISS,  11'h031, 1'b0, 2);
      push_exp(SRC_CPU1, OP_WRITE_MISS, 11'h032, 1'b0, 1);
      push_exp(SRC_CPU0, OP_INVALIDATE, 11'h033, 1'b0, 2);
      serve(SRC_CPU0, 2, 1'b0, w);
      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_INVALIDATE, 11'h033);
      serve(SRC_CPU1, 1, 1'b0, w);
      serve(SRC_CPU0, 2, 1'b0, w);

      // cpu1 invalidate with no bus_done: 16 BUSY cycles then ack with timeout_err.
      @(posedge clk); #1;
      set_req(SRC_CPU1, OP_INVALIDATE, 11'h2A5);
      push_exp(SRC_CPU1, OP_INVALIDATE, 11'h2A5, 1'b1, 16);
      serve(SRC_CPU1, 0, 1'b0, w);

      // bus_done on the expiry cycle: completion wins, no error.
      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_WRITE_MISS, 11'h400);
      push_exp(SRC_CPU0, OP_WRITE_MISS, 11'h400, 1'b0, 16);
      serve(SRC_CPU0, 16, 1'b0, w);

      // Requester changes op/addr after grant: bus keeps the latched values.
      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_READ_MISS, 11'h055);
      push_exp(SRC_CPU0, OP_READ_MISS, 11'h055, 1'b0, 3);
      serve(SRC_CPU0, 3, 1'b1, w);

      // OP_NONE request is ignored.
      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_NONE, 11'h111);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (ifc.bus_valid || ifc.grant_0 || ifc.grant_1) begin
            n_fail++;
            $display("FAIL op_none_ignored: bus_valid=%b grant=%b%b, required 0 00",
                     ifc.bus_valid, ifc.grant_1, ifc.grant_0);
         end
      end
      ifc.req_0 = 1'b0;

      // Reset mid-BUSY; last served was cpu0, but after reset cpu0 must win the tie.
      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_READ_MISS, 11'h0F0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_tests++;
      if (!ifc.bus_valid) begin
         n_fail++;
         $display("FAIL pre_reset_busy: bus_valid=%b, required 1", ifc.bus_valid);
      end
      rst_n = 1'b0;
      ifc.req_0 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_idle_outputs("mid_busy_reset");
      @(posedge clk); #1;
      set_req(SRC_CPU0, OP_INVALIDATE, 11'h3C3);
      set_req(SRC_CPU1, OP_READ_MISS,  11'h5A5);
      push_exp(SRC_CPU0, OP_INVALIDATE, 11'h3C3, 1'b0, 1);
      push_exp(SRC_CPU1, OP_READ_MISS,  11'h5A5, 1'b0, 2);
      serve(SRC_CPU0, 1, 1'b0, w);
      serve(SRC_CPU1, 2, 1'b0, w);

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("final_idle");
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
